shifter_arbiter_16bit: RTL and testbench
========================================

# shifter_arbiter_16bit

Shares one 16-bit left/right logical shift stage (4-bit amount, direction select) between two requesters. Extends the usable shift amount to 0–31 by running the stage for several passes. Each requester presents operands with a req/ack handshake and receives a one-cycle done pulse with the result on a shared output bus. The block sits between the ALU-side command sources and the shift datapath.

## Interface
- No parameters; data width fixed at 16, amount width fixed at 5.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- req  in  2  req[i] = requester i has a pending operation; held until ack[i].
- a0, a1  in  16  operand for requester 0 / 1.
- amt0, amt1  in  5  shift amount 0–31 for requester 0 / 1.
- dir0, dir1  in  1  0 = logical left, 1 = logical right.
- ack  out  2  one-cycle pulse: request i accepted, operands sampled.
- done  out  2  one-cycle pulse: result for requester i valid on y.
- y  out  16  result; holds the last result until the next done.
- busy  out  1  high while an operation is in progress (state SHIFT).

## Operation
- States: IDLE, SHIFT. Reset → IDLE.
- IDLE, no req: stay; outputs ack = 0, done = 0.
- IDLE, req ≠ 0: select winner (see arbitration). On the edge, latch data_r ← a_w, rem_r ← amt_w, dir_r ← dir_w, id_r ← w; ack[w] ← 1 for one cycle; state ← SHIFT.
- SHIFT, each edge: step = min(rem_r, 15); data_r ← stage(data_r, step, dir_r); rem_r ← rem_r − step.
  - If rem_r − step == 0: y ← shifted value; done[id_r] ← 1 for one cycle; state ← IDLE.
  - Otherwise stay in SHIFT.
- Pass count: amt 0–15 = 1 pass; 16–30 = 2 passes; 31 = 3 passes (15 + 15 + 1).
  - amt 0 takes one pass with step 0, so y = a.
- Shifts are logical, zero-filled. Any amount ≥ 16 yields 0.
- Arbitration: last_r records the last granted requester. last_r resets to 1, so requester 0 wins the first tie.
  - Both requesting: grant ~last_r.
  - One requesting: grant that one.
  - last_r updates at every grant.
- Operands are sampled only at the grant edge. Changes while busy have no effect.
- A requester that keeps req high after ack is treated as a new request.
- req changes during SHIFT are ignored until the block returns to IDLE.
- reset mid-operation: the operation is dropped, no done is issued, and the held y is cleared.

## Timing
- Reset values: ack = 0, done = 0, y = 16'h0000, busy = 0, state = IDLE, last_r = 1.
- Request seen in IDLE at edge E0: ack is high in cycle E0→E1, busy is high from E0.
- Passes run at edges E1..En, where n = pass count.
- done and y update at En; busy drops at En.
- Latency from grant edge to done edge = n cycles (1, 2 or 3).
- Earliest next grant is En+1. Back-to-back throughput is one operation per n + 1 cycles.
- ack and done are never high for both bits at once.
- ack and done for different operations never overlap: done at En, next ack at En+1 at the earliest.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- SHIFT_ARB_RR_EN defined: round-robin arbitration via last_r, as described above.
- SHIFT_ARB_RR_EN undefined: fixed priority, requester 0 always wins a tie.
  - last_r is not implemented.
  - Requester 1 can starve if req[0] is held continuously.

## Test plan
- Reset then single left shift: req = 01, a0 = 16'h00F0, amt0 = 4, dir0 = 0 → ack = 01 after E0, done = 01 and y = 16'h0F00 after E1, busy low after E1.
- Right shift, zero amount, requester 1: a1 = 16'hA5A5, amt1 = 0, dir1 = 1 → y = 16'hA5A5 one cycle after grant; then a1 = 16'h8000, amt1 = 15, dir1 = 1 → y = 16'h0001.
- Multi-pass: a0 = 16'hFFFF, amt0 = 31, dir0 = 0 → busy high for 3 cycles, done after E3, y = 16'h0000.
  - a0 = 16'h0001, amt0 = 20, dir0 = 0 → 2 passes, y = 16'h0000.
- Contention: req = 11 held continuously, all amounts = 1 → with SHIFT_ARB_RR_EN, grants alternate 0, 1, 0, 1; without it, only requester 0 is granted.
- Reset mid-operation: grant amt0 = 31, assert reset during the 2nd pass → done never pulses, y = 0, busy = 0.
  - After reset release, req = 11 grants requester 0 first.
- Operand change while busy: a0 changed from 16'h0003 to 16'hFFFF during SHIFT (amt0 = 2, dir0 = 0) → y = 16'h000C.

Source files
------------

// File: rtl/shifter_arbiter_16bit.sv
// Two-requester arbiter around one 16-bit logical shift stage; amounts 0-31 run as up to three passes.
// Optional macro SHIFT_ARB_RR_EN selects round-robin arbitration; otherwise requester 0 has fixed priority.
module shifter_arbiter_16bit (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [15:0] a0,
  input  logic [15:0] a1,
  input  logic [4:0]  amt0,
  input  logic [4:0]  amt1,
  input  logic        dir0,
  input  logic        dir1,
  output logic [1:0]  ack,
  output logic [1:0]  done,
  output logic [15:0] y,
  output logic        busy
);

  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

  state_t      r_state;
  logic [15:0] r_data;
  logic [4:0]  r_rem;
  logic        r_dir;
  logic        r_id;
`ifdef SHIFT_ARB_RR_EN
  logic        r_last;
`endif

  logic        w_win;
  logic [15:0] w_a;
  logic [4:0]  w_amt;
  logic        w_dir;
  logic [3:0]  w_step;
  logic [4:0]  w_rem_next;
  logic [15:0] w_shifted;

  function automatic logic [15:0] stage(input logic [15:0] d, input logic [3:0] s, input logic r);
    return r ? (d >> s) : (d << s);
  endfunction

  // Winner selection and operand mux for the grant edge
  always_comb begin
    w_win = 1'b0;
`ifdef SHIFT_ARB_RR_EN
    if (req == 2'b11) begin
      w_win = ~r_last;
    end else begin
      w_win = req[1];
    end
`else
    if (req[0]) begin
      w_win = 1'b0;
    end else begin
      w_win = req[1];
    end
`endif
    w_a   = w_win ? a1 : a0;
    w_amt = w_win ? amt1 : amt0;
    w_dir = w_win ? dir1 : dir0;
  end

  // Passes are capped at the 4-bit stage limit of 15
  always_comb begin
    w_step     = (r_rem > 5'd15) ? 4'd15 : r_rem[3:0];
    w_rem_next = r_rem - {1'b0, w_step};
    w_shifted  = stage(r_data, w_step, r_dir);
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_data  <= 16'h0000;
      r_rem   <= 5'd0;
      r_dir   <= 1'b0;
      r_id    <= 1'b0;
`ifdef SHIFT_ARB_RR_EN
      r_last  <= 1'b1;
`endif
      ack     <= 2'b00;
      done    <= 2'b00;
      y       <= 16'h0000;
      busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 2'b00;
          if (req != 2'b00) begin
            r_data  <= w_a;
            r_rem   <= w_amt;
            r_dir   <= w_dir;
            r_id    <= w_win;
`ifdef SHIFT_ARB_RR_EN
            r_last  <= w_win;
`endif
            ack     <= w_win ? 2'b10 : 2'b01;
            busy    <= 1'b1;
            r_state <= S_SHIFT;
          end else begin
            ack  <= 2'b00;
            busy <= 1'b0;
          end
        end
        S_SHIFT: begin
          ack    <= 2'b00;
          r_data <= w_shifted;
          r_rem  <= w_rem_next;
          if (w_rem_next == 5'd0) begin
            y       <= w_shifted;
            done    <= r_id ? 2'b10 : 2'b01;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            done <= 2'b00;
          end
        end
        default: begin
          ack     <= 2'b00;
          done    <= 2'b00;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shifter_arbiter_16bit.sv
// Directed self-checking bench for shifter_arbiter_16bit; expectations adapt to SHIFT_ARB_RR_EN.
module tb_shifter_arbiter_16bit;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [15:0] a0, a1;
  logic [4:0]  amt0, amt1;
  logic        dir0, dir1;
  logic [1:0]  ack, done;
  logic [15:0] y;
  logic        busy;

  int checks = 0;
  int failures = 0;

  shifter_arbiter_16bit dut (
    .clk(clk), .reset(reset), .req(req),
    .a0(a0), .a1(a1), .amt0(amt0), .amt1(amt1), .dir0(dir0), .dir1(dir1),
    .ack(ack), .done(done), .y(y), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, drop req after ack, wait (bounded) for done.
  task automatic run_op(input int id, input logic [15:0] a, input logic [4:0] amt, input logic dir,
                        output logic [1:0] acko, output logic [1:0] doneo, output int lat, output int bcnt);
    if (id == 0) begin
      a0 = a; amt0 = amt; dir0 = dir; req = 2'b01;
    end else begin
      a1 = a; amt1 = amt; dir1 = dir; req = 2'b10;
    end
    tick();
    acko = ack;
    bcnt = busy ? 1 : 0;
    req  = 2'b00;
    lat  = 0;
    doneo = 2'b00;
    while (lat < 8 && doneo == 2'b00) begin
      tick();
      lat++;
      if (busy) bcnt++;
      doneo = done;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 2'b00;
    a0 = 16'h0; a1 = 16'h0; amt0 = 5'd0; amt1 = 5'd0; dir0 = 1'b0; dir1 = 1'b0;
    tick();
    checks++; if (ack !== 2'b00) begin failures++; $display("FAIL reset_ack got=%b exp=00", ack); end
    checks++; if (done !== 2'b00) begin failures++; $display("FAIL reset_done got=%b exp=00", done); end
    checks++; if (y !== 16'h0000) begin failures++; $display("FAIL reset_y got=%h exp=0000", y); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_left();
    logic [1:0] ak, dn; int lat, bc;
    run_op(0, 16'h00F0, 5'd4, 1'b0, ak, dn, lat, bc);
    checks++; if (ak !== 2'b01) begin failures++; $display("FAIL left_ack got=%b exp=01", ak); end
    checks++; if (dn !== 2'b01) begin failures++; $display("FAIL left_done got=%b exp=01", dn); end
    checks++; if (y !== 16'h0F00) begin failures++; $display("FAIL left_y got=%h exp=0f00", y); end
    checks++; if (lat != 1) begin failures++; $display("FAIL left_latency got=%0d exp=1", lat); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL left_busy_after got=%b exp=0", busy); end
    tick();
    checks++; if (done !== 2'b00) begin failures++; $display("FAIL left_done_pulse got=%b exp=00", done); end
    checks++; if (y !== 16'h0F00) begin failures++; $display("FAIL left_y_hold got=%h exp=0f00", y); end
  endtask

  task automatic test_right();
    logic [1:0] ak, dn; int lat, bc;
    run_op(1, 16'hA5A5, 5'd0, 1'b1, ak, dn, lat, bc);
    checks++; if (ak !== 2'b10) begin failures++; $display("FAIL right0_ack got=%b exp=10", ak); end
    checks++; if (dn !== 2'b10) begin failures++; $display("FAIL right0_done got=%b exp=10", dn); end
    checks++; if (y !== 16'hA5A5) begin failures++; $display("FAIL right0_y got=%h exp=a5a5", y); end
    checks++; if (lat != 1) begin failures++; $display("FAIL right0_latency got=%0d exp=1", lat); end
    tick();
    run_op(1, 16'h8000, 5'd15, 1'b1, ak, dn, lat, bc);
    checks++; if (y !== 16'h0001) begin failures++; $display("FAIL right15_y got=%h exp=0001", y); end
    checks++; if (lat != 1) begin failures++; $display("FAIL right15_latency got=%0d exp=1", lat); end
    tick();
  endtask

  task automatic test_multipass();
    logic [1:0] ak, dn; int lat, bc;
    run_op(0, 16'h0001, 5'd20, 1'b0, ak, dn, lat, bc);
    checks++; if (y !== 16'h0000) begin failures++; $display("FAIL amt20_y got=%h exp=0000", y); end
    checks++; if (lat != 2) begin failures++; $display("FAIL amt20_latency got=%0d exp=2", lat); end
    checks++; if (bc != 2) begin failures++; $display("FAIL amt20_busy_cycles got=%0d exp=2", bc); end
    tick();
    run_op(1, 16'h0300, 5'd8, 1'b1, ak, dn, lat, bc);
    checks++; if (y !== 16'h0003) begin failures++; $display("FAIL right8_y got=%h exp=0003", y); end
    tick();
    run_op(0, 16'hFFFF, 5'd31, 1'b0, ak, dn, lat, bc);
    checks++; if (dn !== 2'b01) begin failures++; $display("FAIL amt31_done got=%b exp=01", dn); end
    checks++; if (y !== 16'h0000) begin failures++; $display("FAIL amt31_y got=%h exp=0000", y); end
    checks++; if (lat != 3) begin failures++; $display("FAIL amt31_latency got=%0d exp=3", lat); end
    checks++; if (bc != 3) begin failures++; $display("FAIL amt31_busy_cycles got=%0d exp=3", bc); end
    tick();
  endtask

  task automatic test_contention();
    logic [1:0] exp_g [4];
    logic [1:0] got;
    int w;
`ifdef SHIFT_ARB_RR_EN
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`else
    exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b01;
`endif
    a0 = 16'h0001; a1 = 16'h0100; amt0 = 5'd1; amt1 = 5'd1; dir0 = 1'b0; dir1 = 1'b0;
    req = 2'b11;
    for (int g = 0; g < 4; g++) begin
      got = 2'b00; w = 0;
      while (w < 5 && got == 2'b00) begin
        tick(); w++; got = ack;
      end
      checks++; if (got !== exp_g[g]) begin failures++; $display("FAIL contention_grant%0d got=%b exp=%b", g, got, exp_g[g]); end
      tick();
      checks++; if (done !== exp_g[g]) begin failures++; $display("FAIL contention_done%0d got=%b exp=%b", g, done, exp_g[g]); end
    end
    req = 2'b00;
    tick(); tick();
  endtask

  task automatic test_operand_change();
    logic [1:0] dn; int w;
    a0 = 16'h0003; amt0 = 5'd2; dir0 = 1'b0; req = 2'b01;
    tick();
    checks++; if (ack !== 2'b01) begin failures++; $display("FAIL opchg_ack got=%b exp=01", ack); end
    a0 = 16'hFFFF; req = 2'b00;
    dn = 2'b00; w = 0;
    while (w < 6 && dn == 2'b00) begin
      tick(); w++; dn = done;
    end
    checks++; if (dn !== 2'b01) begin failures++; $display("FAIL opchg_done got=%b exp=01", dn); end
    checks++; if (y !== 16'h000C) begin failures++; $display("FAIL opchg_y got=%h exp=000c", y); end
    tick();
  endtask

  task automatic test_reset_mid();
    int dcount;
    a0 = 16'hFFFF; amt0 = 5'd31; dir0 = 1'b0; req = 2'b01;
    tick();
    checks++; if (ack !== 2'b01) begin failures++; $display("FAIL rstmid_ack got=%b exp=01", ack); end
    req = 2'b00;
    tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before got=%b exp=1", busy); end
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (y !== 16'h0000) begin failures++; $display("FAIL rstmid_y got=%h exp=0000", y); end
    tick();
    reset = 1'b0;
    dcount = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (done != 2'b00) dcount++;
    end
    checks++; if (dcount != 0) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=0", dcount); end
    checks++; if (y !== 16'h0000) begin failures++; $display("FAIL rstmid_y_after got=%h exp=0000", y); end
    amt0 = 5'd1; amt1 = 5'd1; req = 2'b11;
    tick();
    checks++; if (ack !== 2'b01) begin failures++; $display("FAIL rstmid_first_grant got=%b exp=01", ack); end
    req = 2'b00;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_left();
    test_right();
    test_multipass();
    test_contention();
    test_operand_change();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
